// File: rtl/mips_mc_controller_if.sv
// -----------------------------------------------------------------------------
// mips_mc_controller_if
//   Control bundle between the multi-cycle MIPS controller and its datapath.
//   master : the controller (takes IR fields, ALU flag and memory ready;
//            drives every datapath select, enable and the ALU operation)
//   slave  : the datapath side of the same bundle
//
//   opcode[5:0]     instruction[31:26] from IR
//   func[5:0]       instruction[5:0] from IR
//   zero            ALU zero flag
//   mem_ready       shared memory access completes this cycle
//   reg_dst[1:0]    0=rt, 1=rd, 2=r31
//   pc_src[1:0]     0=pc+4, 1=rs, 2=jump target, 3=branch target
//   mem_to_reg[1:0] 0=alu, 1=mem, 2=pc+4
//   alu_op[2:0]     000 add, 001 sub, 010 and, 011 or, 100 slt
//   alu_src         0=rt, 1=sign-extended immediate
//   i_or_d          memory address: 0=PC, 1=ALU result
//   mem_read, mem_write, ir_write, pc_write, reg_write  enables
// -----------------------------------------------------------------------------
interface mips_mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic [1:0] reg_dst;
  logic [1:0] pc_src;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_op;
  logic       alu_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;

  modport master (
    input  opcode, func, zero, mem_ready,
    output reg_dst, pc_src, mem_to_reg, alu_op, alu_src, i_or_d,
           mem_read, mem_write, ir_write, pc_write, reg_write
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  reg_dst, pc_src, mem_to_reg, alu_op, alu_src, i_or_d,
           mem_read, mem_write, ir_write, pc_write, reg_write
  );
endinterface

// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//   Multi-cycle control FSM for a MIPS datapath sharing one instruction/data
//   memory behind a ready handshake. Decodes opcode/func from IR and drives
//   the datapath one state at a time; counts retired instructions.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     bus          mips_mc_controller_if.master (IR fields, flags, controls)
//     busy_state   current state encoding (debug)
//     instr_count  retired instructions, wraps modulo 2^CNT_W
//     illegal      (MC_ILLEGAL_TRAP_EN only) controller is in TRAP
//
//   Parameters:
//     CNT_W        width of instr_count
//
//   Build option MC_ILLEGAL_TRAP_EN:
//     defined   - unknown opcode parks the FSM in TRAP until reset
//     undefined - unknown opcode retires as a 3-cycle NOP
// -----------------------------------------------------------------------------
module mips_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_controller_if.master bus,
  output logic [2:0]           busy_state,
  output logic [CNT_W-1:0]     instr_count
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // TRAP needs a distinct internal code, but reports 7 on busy_state.
`ifdef MC_ILLEGAL_TRAP_EN
  localparam int STATE_W = 4;
`else
  localparam int STATE_W = 3;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    EXEC   = STATE_W'(2),
    MEM_RD = STATE_W'(3),
    MEM_WR = STATE_W'(4),
    WB     = STATE_W'(5),
    BRANCH = STATE_W'(6),
    JUMP   = STATE_W'(7)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    TRAP   = STATE_W'(15)
`endif
  } state_t;

  typedef enum logic [3:0] {
    I_RTYPE, I_JR, I_LW, I_SW, I_ADDI, I_SLTI,
    I_BEQ, I_BNE, I_J, I_JAL, I_ILL
  } iclass_t;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
  } ctrl_t;

  state_t     state, state_next;
  iclass_t    iclass;
  logic [2:0] r_alu_op;
  logic [2:0] ex_alu_op;
  logic       ex_alu_src;
  ctrl_t      ctrl, ctrl_out;

  // Instruction class from the IR fields.
  always_comb begin
    iclass = I_ILL;
    case (bus.opcode)
      OP_RTYPE: iclass = (bus.func == FN_JR) ? I_JR : I_RTYPE;
      OP_LW:    iclass = I_LW;
      OP_SW:    iclass = I_SW;
      OP_ADDI:  iclass = I_ADDI;
      OP_SLTI:  iclass = I_SLTI;
      OP_BEQ:   iclass = I_BEQ;
      OP_BNE:   iclass = I_BNE;
      OP_J:     iclass = I_J;
      OP_JAL:   iclass = I_JAL;
      default:  iclass = I_ILL;
    endcase
  end

  // R-type ALU operation; an unrecognised func falls back to add.
  always_comb begin
    r_alu_op = ALU_ADD;
    case (bus.func)
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_ADD:  r_alu_op = ALU_ADD;
      default: r_alu_op = ALU_ADD;
    endcase
  end

  // ALU setup used in EXEC and held through WB so the result stays stable.
  always_comb begin
    ex_alu_src = 1'b0;
    ex_alu_op  = ALU_ADD;
    case (iclass)
      I_RTYPE:          ex_alu_op  = r_alu_op;
      I_LW, I_SW,
      I_ADDI:           ex_alu_src = 1'b1;
      I_SLTI: begin
        ex_alu_src = 1'b1;
        ex_alu_op  = ALU_SLT;
      end
      default: ;
    endcase
  end

  // NOTE: every signal of a combinational block gets a default before the
  // case, so a path that forgets to assign it cannot infer a latch.
  always_comb begin
    ctrl       = '0;
    state_next = state;
    case (state)
      FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = bus.mem_ready;
        if (bus.mem_ready) state_next = DECODE;
      end

      DECODE: begin
        case (iclass)
          I_RTYPE, I_LW, I_SW, I_ADDI, I_SLTI: state_next = EXEC;
          I_BEQ, I_BNE:                        state_next = BRANCH;
          I_J, I_JAL, I_JR:                    state_next = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:                             state_next = TRAP;
`else
          default:                             state_next = WB;
`endif
        endcase
      end

      EXEC: begin
        ctrl.alu_src = ex_alu_src;
        ctrl.alu_op  = ex_alu_op;
        case (iclass)
          I_LW:    state_next = MEM_RD;
          I_SW:    state_next = MEM_WR;
          default: state_next = WB;
        endcase
      end

      MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        if (bus.mem_ready) state_next = WB;
      end

      MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        if (bus.mem_ready) begin
          ctrl.pc_write = 1'b1;
          state_next    = FETCH;
        end
      end

      WB: begin
        ctrl.pc_write = 1'b1;
        ctrl.alu_src  = ex_alu_src;
        ctrl.alu_op   = ex_alu_op;
        case (iclass)
          I_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 2'd1;
          end
          I_ADDI, I_SLTI: ctrl.reg_write = 1'b1;
          I_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 2'd1;
          end
          default: ;  // unknown opcode: NOP that only advances the PC
        endcase
        state_next = FETCH;
      end

      BRANCH: begin
        ctrl.alu_src  = 1'b0;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_write = 1'b1;
        if ((iclass == I_BEQ && bus.zero) || (iclass == I_BNE && !bus.zero))
          ctrl.pc_src = 2'd3;
        state_next = FETCH;
      end

      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = (iclass == I_JR) ? 2'd1 : 2'd2;
        if (iclass == I_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 2'd2;
          ctrl.mem_to_reg = 2'd2;
        end
        state_next = FETCH;
      end

`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: state_next = TRAP;  // parked with all enables low until reset
`endif

      default: state_next = FETCH;
    endcase
  end

  // NOTE: reset is asynchronous, so the state register alone would still let
  // FETCH drive mem_read while rst is low; gating here forces every control
  // to 0 the instant reset asserts, aborting any write in progress.
  assign ctrl_out = rst ? ctrl : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (ctrl_out.pc_write) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign busy_state     = state[2:0];
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal        = (state == TRAP);
`endif

  assign bus.reg_dst    = ctrl_out.reg_dst;
  assign bus.pc_src     = ctrl_out.pc_src;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.alu_op     = ctrl_out.alu_op;
  assign bus.alu_src    = ctrl_out.alu_src;
  assign bus.i_or_d     = ctrl_out.i_or_d;
  assign bus.mem_read   = ctrl_out.mem_read;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.ir_write   = ctrl_out.ir_write;
  assign bus.pc_write   = ctrl_out.pc_write;
  assign bus.reg_write  = ctrl_out.reg_write;

endmodule

// File: tb/tb_mips_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_controller
//   Self-checking bench for mips_mc_controller. Directed scenarios follow the
//   controller's documented behaviour; a randomized instruction stream is
//   compared per instruction against a reference model that predicts latency,
//   the final-cycle controls and the number of cycles each enable is high.
//   A second instance with a 3-bit counter exercises counter wrap-around.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_mc_controller;

  localparam int CNT_W   = 32;
  localparam int SMALL_W = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;

  mips_mc_controller_if bus ();
  mips_mc_controller_if bus_s ();

  assign bus.opcode      = opcode;
  assign bus.func        = func;
  assign bus.zero        = zero;
  assign bus.mem_ready   = mem_ready;
  assign bus_s.opcode    = opcode;
  assign bus_s.func      = func;
  assign bus_s.zero      = zero;
  assign bus_s.mem_ready = mem_ready;

  logic [2:0]         busy_state, busy_state_s;
  logic [CNT_W-1:0]   instr_count;
  logic [SMALL_W-1:0] instr_count_s;
`ifdef MC_ILLEGAL_TRAP_EN
  logic               illegal, illegal_s;
`endif

  mips_mc_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .busy_state  (busy_state),
    .instr_count (instr_count)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  mips_mc_controller #(.CNT_W(SMALL_W)) dut_small (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_s.master),
    .busy_state  (busy_state_s),
    .instr_count (instr_count_s)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal_s)
`endif
  );

  typedef struct {
    logic [2:0]       st;
    logic [1:0]       reg_dst;
    logic [1:0]       pc_src;
    logic [1:0]       mem_to_reg;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             ill;
  } snap_t;

  // Reference expectations for one instruction.
  typedef struct {
    int         lat;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       wr_reg;
    logic [2:0] last_st;
    bit         is_lw;
    bit         is_sw;
    bit         retire;
  } exp_t;

  snap_t            trace[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_count;

  function automatic snap_t capture();
    snap_t s;
    s.st         = busy_state;
    s.reg_dst    = bus.reg_dst;
    s.pc_src     = bus.pc_src;
    s.mem_to_reg = bus.mem_to_reg;
    s.alu_op     = bus.alu_op;
    s.alu_src    = bus.alu_src;
    s.i_or_d     = bus.i_or_d;
    s.mem_read   = bus.mem_read;
    s.mem_write  = bus.mem_write;
    s.ir_write   = bus.ir_write;
    s.pc_write   = bus.pc_write;
    s.reg_write  = bus.reg_write;
`ifdef MC_ILLEGAL_TRAP_EN
    s.ill        = illegal;
`else
    s.ill        = 1'b0;
`endif
    return s;
  endfunction

  function automatic logic [15:0] ctrl_bits(snap_t s);
    return {s.reg_dst, s.pc_src, s.mem_to_reg, s.alu_op, s.alu_src, s.i_or_d,
            s.mem_read, s.mem_write, s.ir_write, s.pc_write, s.reg_write};
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_ADDI ||
           op == OP_SLTI || op == OP_BEQ || op == OP_BNE || op == OP_J ||
           op == OP_JAL;
  endfunction

  // Spec-level table: latency, final-cycle controls, retirement.
  function automatic exp_t expect_of(logic [5:0] op, logic [5:0] fn, logic z,
                                     int fw, int mw);
    exp_t e;
    e = '{lat: 3 + fw, reg_dst: 2'd0, mem_to_reg: 2'd0, pc_src: 2'd0,
          alu_op: 3'd0, alu_src: 1'b0, wr_reg: 1'b0, last_st: 3'd5,
          is_lw: 1'b0, is_sw: 1'b0, retire: 1'b1};
    case (op)
      OP_R: begin
        if (fn == FN_JR) begin
          e.pc_src = 2'd1; e.last_st = 3'd7;
        end else begin
          e.lat = 4 + fw; e.wr_reg = 1'b1; e.reg_dst = 2'd1; e.alu_op = r_alu(fn);
        end
      end
      OP_LW: begin
        e.lat = 5 + fw + mw; e.wr_reg = 1'b1; e.mem_to_reg = 2'd1;
        e.alu_src = 1'b1; e.is_lw = 1'b1;
      end
      OP_SW: begin
        e.lat = 4 + fw + mw; e.alu_src = 1'b1; e.last_st = 3'd4; e.is_sw = 1'b1;
      end
      OP_ADDI: begin
        e.lat = 4 + fw; e.wr_reg = 1'b1; e.alu_src = 1'b1;
      end
      OP_SLTI: begin
        e.lat = 4 + fw; e.wr_reg = 1'b1; e.alu_src = 1'b1; e.alu_op = 3'b100;
      end
      OP_BEQ: begin
        e.alu_op = 3'b001; e.last_st = 3'd6; e.pc_src = z ? 2'd3 : 2'd0;
      end
      OP_BNE: begin
        e.alu_op = 3'b001; e.last_st = 3'd6; e.pc_src = z ? 2'd0 : 2'd3;
      end
      OP_J:   begin e.pc_src = 2'd2; e.last_st = 3'd7; end
      OP_JAL: begin
        e.pc_src = 2'd2; e.last_st = 3'd7; e.wr_reg = 1'b1;
        e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
      end
      default: ;  // unknown opcode as a 3-cycle NOP
    endcase
    return e;
  endfunction

  // Drive one instruction for ncyc cycles; mem_ready is low for fw FETCH
  // cycles and (for memory ops) mw cycles of the memory phase, random where
  // it has no meaning. One snapshot per cycle is taken at the falling edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw,
                           input bit is_mem, input int ncyc);
    trace.delete();
    opcode = op;
    func   = fn;
    zero   = z;
    for (int c = 0; c < ncyc; c++) begin
      if (c < fw)                                      mem_ready = 1'b0;
      else if (c == fw)                                mem_ready = 1'b1;
      else if (is_mem && c >= fw + 3 && c < fw + 3 + mw) mem_ready = 1'b0;
      else if (is_mem && c == fw + 3 + mw)             mem_ready = 1'b1;
      else                                             mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      trace.push_back(capture());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] ops [9];
    int         k;
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    fn  = 6'($urandom);
`ifdef MC_ILLEGAL_TRAP_EN
    k = $urandom_range(0, 8);
`else
    k = $urandom_range(0, 9);
`endif
    if (k == 9) begin
      do op = 6'($urandom); while (is_legal(op));
    end else begin
      op = ops[k];
    end
    if (op == OP_R) begin
      case ($urandom_range(0, 7))
        0: fn = FN_JR;
        1: fn = 6'b100000;
        2: fn = 6'b100010;
        3: fn = 6'b100100;
        4: fn = 6'b100101;
        5: fn = 6'b101010;
        default: fn = 6'b000111;  // unrecognised func
      endcase
    end
  endtask

  task automatic test_reset();
    snap_t s;
    rst = 1'b0; opcode = OP_LW; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s = capture();
    checks++;
    if (ctrl_bits(s) !== 16'h0) begin
      errors++; $display("FAIL reset_ctrl got=%h want=0000", ctrl_bits(s));
    end
    checks++;
    if (busy_state !== 3'd0 || busy_state_s !== 3'd0) begin
      errors++; $display("FAIL reset_state got=%0d/%0d want=0", busy_state, busy_state_s);
    end
    checks++;
    if (instr_count !== '0 || instr_count_s !== '0) begin
      errors++; $display("FAIL reset_count got=%0d/%0d want=0", instr_count, instr_count_s);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_rtype_add();
    run_instr(OP_R, 6'b100000, 1'b0, 0, 0, 1'b0, 4);
    exp_count++;
    checks++;
    if ({trace[0].st, trace[1].st, trace[2].st, trace[3].st} !== {3'd0, 3'd1, 3'd2, 3'd5}) begin
      errors++;
      $display("FAIL add_states got=%0d,%0d,%0d,%0d want=0,1,2,5",
               trace[0].st, trace[1].st, trace[2].st, trace[3].st);
    end
    checks++;
    if ({trace[3].reg_write, trace[3].reg_dst, trace[3].pc_write, trace[3].alu_op} !==
        {1'b1, 2'd1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL add_wb got rw=%b rd=%0d pw=%b op=%b want rw=1 rd=1 pw=1 op=000",
               trace[3].reg_write, trace[3].reg_dst, trace[3].pc_write, trace[3].alu_op);
    end
    checks++;
    if (instr_count !== exp_count || exp_count !== CNT_W'(1)) begin
      errors++; $display("FAIL add_count got=%0d want=1", instr_count);
    end
  endtask

  task automatic test_lw_waits();
    int exp_st [10];
    int bad;
    exp_st = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 5};
    run_instr(OP_LW, 6'd0, 1'b0, 2, 3, 1'b1, 10);
    exp_count++;
    bad = 0;
    for (int i = 0; i < 10; i++) if (int'(trace[i].st) != exp_st[i]) bad++;
    checks++;
    if (bad != 0 || busy_state !== 3'd0) begin
      errors++; $display("FAIL lw_states mismatched=%0d next_state=%0d want 0 and 0", bad, busy_state);
    end
    bad = 0;
    for (int i = 5; i < 9; i++) if (!(trace[i].i_or_d && trace[i].mem_read)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL lw_memrd cycles_without_read=%0d want=0", bad);
    end
    checks++;
    if ({trace[9].mem_to_reg, trace[9].reg_dst, trace[9].reg_write} !== {2'd1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL lw_wb got m2r=%0d rd=%0d rw=%b want 1 0 1",
               trace[9].mem_to_reg, trace[9].reg_dst, trace[9].reg_write);
    end
  endtask

  task automatic test_branch();
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0, 3);
    exp_count++;
    checks++;
    if ({trace[2].st, trace[2].pc_src, trace[2].pc_write, busy_state} !== {3'd6, 2'd3, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL beq_taken got st=%0d src=%0d pw=%b next=%0d want 6 3 1 0",
               trace[2].st, trace[2].pc_src, trace[2].pc_write, busy_state);
    end
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b0, 3);
    exp_count++;
    checks++;
    if ({trace[2].st, trace[2].pc_src, trace[2].pc_write, busy_state} !== {3'd6, 2'd0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL bne_not_taken got st=%0d src=%0d pw=%b next=%0d want 6 0 1 0",
               trace[2].st, trace[2].pc_src, trace[2].pc_write, busy_state);
    end
  endtask

  task automatic test_jal_jr();
    run_instr(OP_JAL, 6'd0, 1'b0, 0, 0, 1'b0, 3);
    exp_count++;
    checks++;
    if ({trace[2].st, trace[2].pc_src, trace[2].reg_write, trace[2].reg_dst, trace[2].mem_to_reg}
        !== {3'd7, 2'd2, 1'b1, 2'd2, 2'd2}) begin
      errors++;
      $display("FAIL jal got st=%0d src=%0d rw=%b rd=%0d m2r=%0d want 7 2 1 2 2",
               trace[2].st, trace[2].pc_src, trace[2].reg_write, trace[2].reg_dst, trace[2].mem_to_reg);
    end
    run_instr(OP_R, FN_JR, 1'b0, 0, 0, 1'b0, 3);
    exp_count++;
    checks++;
    if ({trace[2].st, trace[2].pc_src, trace[2].reg_write, trace[2].pc_write, busy_state}
        !== {3'd7, 2'd1, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL jr got st=%0d src=%0d rw=%b pw=%b next=%0d want 7 1 0 1 0",
               trace[2].st, trace[2].pc_src, trace[2].reg_write, trace[2].pc_write, busy_state);
    end
  endtask

  task automatic test_reset_mem_wr();
    int pw;
    run_instr(OP_SW, 6'd0, 1'b0, 0, 5, 1'b1, 4);
    pw = 0;
    foreach (trace[i]) pw += int'(trace[i].pc_write);
    checks++;
    if (busy_state !== 3'd4 || bus.mem_write !== 1'b1 || pw != 0) begin
      errors++;
      $display("FAIL sw_stall got st=%0d mw=%b pc_writes=%0d want 4 1 0", busy_state, bus.mem_write, pw);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_state !== 3'd0 || bus.mem_write !== 1'b0 || bus.pc_write !== 1'b0 || instr_count !== '0) begin
      errors++;
      $display("FAIL async_reset got st=%0d mw=%b pw=%b cnt=%0d want 0 0 0 0",
               busy_state, bus.mem_write, bus.pc_write, instr_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic       z;
    int         fw, mw, pw, rw, mr, mwr, iod, irw;
    exp_t       e;
    snap_t      l;
    for (int n = 0; n < 150; n++) begin
      rand_instr(op, fn);
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      e  = expect_of(op, fn, z, fw, mw);
      run_instr(op, fn, z, fw, mw, e.is_lw || e.is_sw, e.lat);
      if (e.retire) exp_count++;
      pw = 0; rw = 0; mr = 0; mwr = 0; iod = 0; irw = 0;
      foreach (trace[i]) begin
        pw  += int'(trace[i].pc_write);
        rw  += int'(trace[i].reg_write);
        mr  += int'(trace[i].mem_read);
        mwr += int'(trace[i].mem_write);
        iod += int'(trace[i].i_or_d);
        irw += int'(trace[i].ir_write);
      end
      l = trace[e.lat-1];
      checks++;
      if (trace[0].st !== 3'd0 || l.st !== e.last_st) begin
        errors++;
        $display("FAIL rnd_state op=%b fn=%b first=%0d last=%0d want 0 %0d", op, fn, trace[0].st, l.st, e.last_st);
      end
      checks++;
      if (pw != 1 || l.pc_write !== 1'b1 || l.pc_src !== e.pc_src) begin
        errors++;
        $display("FAIL rnd_pc op=%b fn=%b z=%b writes=%0d last_pw=%b src=%0d want 1 1 %0d",
                 op, fn, z, pw, l.pc_write, l.pc_src, e.pc_src);
      end
      checks++;
      if (rw != int'(e.wr_reg) || l.reg_write !== e.wr_reg || l.reg_dst !== e.reg_dst ||
          l.mem_to_reg !== e.mem_to_reg) begin
        errors++;
        $display("FAIL rnd_regwrite op=%b fn=%b rw=%0d rd=%0d m2r=%0d want %0d %0d %0d",
                 op, fn, rw, l.reg_dst, l.mem_to_reg, e.wr_reg, e.reg_dst, e.mem_to_reg);
      end
      checks++;
      if (l.alu_op !== e.alu_op || l.alu_src !== e.alu_src) begin
        errors++;
        $display("FAIL rnd_alu op=%b fn=%b got=%b/%b want=%b/%b", op, fn, l.alu_op, l.alu_src, e.alu_op, e.alu_src);
      end
      checks++;
      if (mr != fw + 1 + (e.is_lw ? mw + 1 : 0) || mwr != (e.is_sw ? mw + 1 : 0) ||
          iod != (e.is_lw || e.is_sw ? mw + 1 : 0)) begin
        errors++;
        $display("FAIL rnd_mem op=%b fw=%0d mw=%0d rd=%0d wr=%0d iod=%0d", op, fw, mw, mr, mwr, iod);
      end
      checks++;
      if (irw != 1 || trace[fw].ir_write !== 1'b1) begin
        errors++; $display("FAIL rnd_irwrite op=%b fw=%0d count=%0d want 1 at fetch end", op, fw, irw);
      end
      checks++;
      if (instr_count !== exp_count || instr_count_s !== exp_count[SMALL_W-1:0]) begin
        errors++;
        $display("FAIL rnd_count got=%0d small=%0d want=%0d small=%0d",
                 instr_count, instr_count_s, exp_count, exp_count[SMALL_W-1:0]);
      end
    end
  endtask

  task automatic test_illegal();
    int bad;
`ifdef MC_ILLEGAL_TRAP_EN
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0, 3);
    checks++;
    if ({trace[2].st, trace[2].ill, ctrl_bits(trace[2])} !== {3'd7, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL trap_enter got st=%0d ill=%b ctrl=%h want 7 1 0000",
               trace[2].st, trace[2].ill, ctrl_bits(trace[2]));
    end
    run_instr(OP_R, 6'b100000, 1'b0, 0, 0, 1'b0, 8);
    bad = 0;
    foreach (trace[i]) if (trace[i].st !== 3'd7 || trace[i].ill !== 1'b1 || ctrl_bits(trace[i]) !== 16'h0) bad++;
    checks++;
    if (bad != 0 || instr_count !== exp_count || illegal_s !== 1'b1) begin
      errors++;
      $display("FAIL trap_hold bad_cycles=%0d cnt=%0d want 0 %0d", bad, instr_count, exp_count);
    end
`else
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0, 3);
    exp_count++;
    bad = 0;
    foreach (trace[i]) bad += int'(trace[i].reg_write);
    checks++;
    if ({trace[2].st, trace[2].pc_write, trace[2].pc_src, busy_state} !== {3'd5, 1'b1, 2'd0, 3'd0} || bad != 0) begin
      errors++;
      $display("FAIL illegal_nop got st=%0d pw=%b src=%0d next=%0d reg_writes=%0d want 5 1 0 0 0",
               trace[2].st, trace[2].pc_write, trace[2].pc_src, busy_state, bad);
    end
    checks++;
    if (instr_count !== exp_count) begin
      errors++; $display("FAIL illegal_count got=%0d want=%0d", instr_count, exp_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_waits();
    test_branch();
    test_jal_jr();
    test_reset_mem_wr();
    test_random();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath, moving it to a shared instruction/data memory with a ready handshake.
- Decodes opcode/func from the instruction register and drives all datapath selects, write enables and the ALU operation one state at a time.
- Counts retired instructions for debug.
- Sits beside the datapath and replaces the combinational single-cycle controller.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- opcode  input  6  instruction[31:26], from IR
- func  input  6  instruction[5:0], from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- reg_dst  output  2  0=rt, 1=rd, 2=r31
- pc_src  output  2  0=pc+4, 1=rs (jr), 2=jump target, 3=branch target
- mem_to_reg  output  2  0=alu, 1=mem, 2=pc+4
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- alu_src  output  1  0=rt, 1=sign-extended imm
- i_or_d  output  1  memory address: 0=PC, 1=ALU result
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR
- pc_write  output  1  load PC from pc_src mux
- reg_write  output  1  register file write
- busy_state  output  3  current state encoding, for debug
- instr_count  output  CNT_W  retired instructions

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, BRANCH=6, JUMP=7.
- rst low (async): state=FETCH, instr_count=0. All enables and selects are 0 while rst is low.
- Reset mid-instruction aborts it with no further PC, register or memory writes.
- Outputs are combinational from state, opcode, func, zero and mem_ready. Any output not listed for a state is 0.
- FETCH: i_or_d=0, mem_read=1. Hold while mem_ready=0. When mem_ready=1: ir_write=1 that cycle, then go to DECODE.
- DECODE: one cycle, no enables.
  - R-type (000000) with func != 001000, lw 100011, sw 101011, addi 001000, slti 001010 -> EXEC.
  - beq 000100, bne 000101 -> BRANCH.
  - j 000010, jal 000011, R-type jr (func 001000) -> JUMP.
- EXEC: one cycle.
  - R-type: alu_src=0; alu_op from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - lw/sw/addi: alu_src=1, add. slti: alu_src=1, slt.
  - Next state: lw -> MEM_RD, sw -> MEM_WR, otherwise WB.
- MEM_RD: i_or_d=1, mem_read=1, alu_src=1, alu_op=add (address held). Hold until mem_ready, then WB.
- MEM_WR: i_or_d=1, mem_write=1, address held as in MEM_RD. On mem_ready: pc_write=1, pc_src=0, -> FETCH.
- WB: reg_write=1, pc_write=1, pc_src=0; ALU inputs held as in EXEC; -> FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi/slti: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
- BRANCH: alu_src=0, alu_op=sub, pc_write=1; -> FETCH.
  - pc_src=3 if taken (beq and zero=1, or bne and zero=0); else pc_src=0.
- JUMP: pc_write=1; -> FETCH.
  - j: pc_src=2. jr: pc_src=1.
  - jal: pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
- PC is written only in the last state of each instruction, so pc+4 is still valid for jal.
- Unrecognised R-type func: alu_op=add and the write proceeds (defined, not trapped).
- instr_count increments (modulo 2^CNT_W) on every cycle where pc_write=1. Wraps from all-ones to 0.
- Latency with zero wait states: R/addi/slti 4 cycles, lw 5, sw 4, beq/bne/j/jal/jr 3. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE goes to a TRAP state (encoding 7 is shared with JUMP on busy_state; an added 1-bit output illegal=1 distinguishes it).
  - TRAP holds all enables at 0 until reset. instr_count is frozen.
- Undefined:
  - Unknown opcode goes DECODE -> WB with reg_write=0, pc_write=1, pc_src=0 (treated as NOP, 3 cycles, counted as retired).
  - The illegal port is absent.

Test Plan:
- Reset, then R-type add (opcode 0, func 100000), mem_ready=1 always -> states 0,1,2,5. In WB: reg_write=1, reg_dst=1, pc_write=1. instr_count=1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total. MEM_RD has i_or_d=1 and mem_read=1 throughout. WB has mem_to_reg=1, reg_dst=0.
- beq with zero=1, then bne with zero=1 -> first BRANCH cycle pc_src=3, second pc_src=0. Both have pc_write=1. Each is 3 cycles.
- jal -> JUMP cycle has pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. Then jr (func 001000) -> pc_src=1, reg_write=0.
- rst driven low in MEM_WR while mem_ready=0 -> state=0 and mem_write=0 immediately, no pc_write, instr_count=0.
- Opcode 111111 -> with MC_ILLEGAL_TRAP_EN: illegal=1, stuck, count unchanged. Without it: 3-cycle NOP, pc_write=1, reg_write=0, count+1.
